// File: rtl/mem_pkg.sv
// Shared memory-port definitions: widths, sequencer states, port indices
// and the CPU read/write encoding.
package mem_pkg;

  localparam int AW = 10;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick; a forced index (lock holder) overrides fairness.
import mem_pkg::*;

module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_en,
  input  logic       force_idx,
  output logic       valid,
  output logic       idx
);

  // On a tie the port that did not win last time goes next.
  always_comb begin
    valid = 1'b0;
    idx   = PORT_CPU;
    if (force_en) begin
      valid = req[force_idx];
      idx   = force_idx;
    end else begin
      valid = |req;
      idx   = (&req) ? ~last : req[PORT_LDR];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between the CPU and the loader
// with a three-state sequencer, round-robin arbitration and a lock watchdog.
import mem_pkg::*;

module mem_port_arbiter #(
  parameter int AW           = mem_pkg::AW,
  parameter int DW           = mem_pkg::DW,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [1:0]    lock,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata,
  output logic          lock_err,
  output logic          mem_read_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_out,
  input  logic [DW-1:0] mem_data_in
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t    state;
  logic          owner;
  logic          last;
  logic          owner_locked;
  logic [CW-1:0] wd_count;
  logic          pick_valid;
  logic          pick_idx;

  rr_pick2 u_pick (
    .req       (req),
    .last      (last),
    .force_en  (owner_locked),
    .force_idx (owner),
    .valid     (pick_valid),
    .idx       (pick_idx)
  );

  // A locked owner that stops requesting is starved out by the watchdog;
  // the release cycle itself grants nothing so arbitration restarts cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      gnt            <= '0;
      done           <= '0;
      rdata          <= '0;
      lock_err       <= 1'b0;
      mem_read_write <= MEM_READ;
      mem_address    <= '0;
      mem_data_out   <= '0;
      owner          <= PORT_CPU;
      last           <= PORT_LDR;
      owner_locked   <= 1'b0;
      wd_count       <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (owner_locked && !req[owner]) begin
            if (wd_count == CW'(LOCK_TIMEOUT)) begin
              owner_locked <= 1'b0;
              lock_err     <= 1'b1;
              wd_count     <= '0;
            end else begin
              wd_count <= wd_count + 1'b1;
            end
          end else begin
            wd_count <= '0;
            if (pick_valid) begin
              state          <= ISSUE;
              gnt[pick_idx]  <= 1'b1;
              owner          <= pick_idx;
              last           <= pick_idx;
              owner_locked   <= lock[pick_idx];
              mem_read_write <= we[pick_idx];
              mem_address    <= addr[pick_idx*AW +: AW];
              mem_data_out   <= wdata[pick_idx*DW +: DW];
            end
          end
        end
        ISSUE: begin
          mem_read_write <= MEM_READ;
          wd_count       <= '0;
          state          <= WAIT;
        end
        WAIT: begin
          done[owner]  <= 1'b1;
          rdata        <= mem_data_in;
          owner_locked <= lock[owner];
          wd_count     <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-port request queues drive the DUT and a
// transaction-level model predicts every output edge by edge.
import mem_pkg::*;

module tb_mem_port_arbiter;

  localparam int TO = 15;

  typedef struct {
    logic        w;
    logic [9:0]  a;
    logic [15:0] d;
    logic        l;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [1:0]  lock = '0;
  logic [19:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [15:0] rdata;
  logic        lock_err;
  logic        mem_read_write;
  logic [9:0]  mem_address;
  logic [15:0] mem_data_out;
  logic [15:0] mem_data_in;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(10), .DW(16), .LOCK_TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .we             (we),
    .lock           (lock),
    .addr           (addr),
    .wdata          (wdata),
    .gnt            (gnt),
    .done           (done),
    .rdata          (rdata),
    .lock_err       (lock_err),
    .mem_read_write (mem_read_write),
    .mem_address    (mem_address),
    .mem_data_out   (mem_data_out),
    .mem_data_in    (mem_data_in)
  );

  function automatic logic [15:0] init_val(int i);
    return (i == 5) ? 16'h1234 : 16'((i * 40503) ^ 16'h5A5A);
  endfunction

  // Synchronous-read memory: data for an address presented at edge E
  // appears after edge E+1.
  logic [15:0] mem [1024];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_read_write) begin
      mem[mem_address] <= mem_data_out;
    end
    mem_data_in <= mem[mem_address];
  end

  int tests_run = 0;
  int tests_failed = 0;

  txn_t        q0[$];
  txn_t        q1[$];
  logic [1:0]  idle_lock = '0;

  logic [15:0] mem_ref [1024];
  int          e = 0;
  int          next_arb = 0;
  int          done_edge = -1;
  int          owner = 0;
  int          last = 1;
  logic        locked = 1'b0;
  int          idle = 0;
  logic        exp_lock_err = 1'b0;
  logic        cur_we = 1'b0;
  logic [15:0] cur_rd = '0;
  logic [1:0]  exp_gnt, exp_done;
  logic        exp_rw, chk_mem, chk_rdata;
  logic [9:0]  exp_addr = '0;
  logic [15:0] exp_wd = '0;
  logic [15:0] exp_rdata = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", tag, e, got, exp);
    end
  endtask

  task automatic applyStimulus();
    if (q0.size() > 0) begin
      req[0] = 1'b1; we[0] = q0[0].w; addr[9:0] = q0[0].a;
      wdata[15:0] = q0[0].d; lock[0] = q0[0].l;
    end else begin
      req[0] = 1'b0; lock[0] = idle_lock[0];
    end
    if (q1.size() > 0) begin
      req[1] = 1'b1; we[1] = q1[0].w; addr[19:10] = q1[0].a;
      wdata[31:16] = q1[0].d; lock[1] = q1[0].l;
    end else begin
      req[1] = 1'b0; lock[1] = idle_lock[1];
    end
  endtask

  task automatic grant(input int w);
    txn_t t;
    t = (w == 0) ? q0.pop_front() : q1.pop_front();
    exp_gnt[w] = 1'b1;
    owner = w; last = w; locked = lock[w];
    exp_rw = t.w; exp_addr = t.a; exp_wd = t.d; chk_mem = 1'b1;
    cur_we = t.w;
    if (t.w) mem_ref[t.a] = t.d;
    else     cur_rd = mem_ref[t.a];
    done_edge = e + 2;
    next_arb  = e + 3;
  endtask

  // Predicts the outputs after the coming edge from the inputs now driven.
  task automatic model_edge();
    int w;
    exp_gnt = '0; exp_done = '0; exp_rw = 1'b0; chk_mem = 1'b0; chk_rdata = 1'b0;
    if (reset) begin
      owner = 0; last = 1; locked = 1'b0; idle = 0; exp_lock_err = 1'b0;
      next_arb = e + 1; done_edge = -1;
      exp_rdata = '0; chk_rdata = 1'b1;
      exp_addr = '0; exp_wd = '0; chk_mem = 1'b1;
    end else if (e < next_arb) begin
      if (e == done_edge) begin
        exp_done[owner] = 1'b1;
        locked = lock[owner];
        if (!cur_we) begin exp_rdata = cur_rd; chk_rdata = 1'b1; end
      end
    end else if (locked && !req[owner]) begin
      if (idle == TO) begin
        locked = 1'b0; exp_lock_err = 1'b1; idle = 0;
      end else begin
        idle++;
      end
    end else begin
      idle = 0;
      w = -1;
      if (locked)          w = owner;
      else if (req == 2'b11) w = 1 - last;
      else if (req[0])     w = 0;
      else if (req[1])     w = 1;
      if (w >= 0) grant(w);
    end
  endtask

  task automatic step();
    applyStimulus();
    model_edge();
    @(posedge clk);
    #1;
    checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("done", 32'(done), 32'(exp_done));
    checkOutput("mem_read_write", 32'(mem_read_write), 32'(exp_rw));
    checkOutput("lock_err", 32'(lock_err), 32'(exp_lock_err));
    if (chk_mem) begin
      checkOutput("mem_address", 32'(mem_address), 32'(exp_addr));
      checkOutput("mem_data_out", 32'(mem_data_out), 32'(exp_wd));
    end
    if (chk_rdata) checkOutput("rdata", 32'(rdata), 32'(exp_rdata));
    e++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); idle_lock = '0;
    reset = 1'b1;
    run(2);
    reset = 1'b0;
  endtask

  function automatic txn_t mk(input logic w, input logic [9:0] a, input logic [15:0] d, input logic l);
    txn_t t;
    t.w = w; t.a = a; t.d = d; t.l = l;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    logic [9:0] a;
    a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
    return mk(1'($urandom_range(0, 1)), a, 16'($urandom), ($urandom_range(0, 3) == 0));
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem_ref[i] = init_val(i);
    do_reset();

    // Single read of the preloaded word.
    q0.push_back(mk(1'b0, 10'h005, 16'h0, 1'b0));
    run(4);
    checkOutput("read_0x005", 32'(rdata), 32'h1234);

    // Loader write followed by a CPU read of the same word.
    q1.push_back(mk(1'b1, 10'h3FF, 16'hBEEF, 1'b0));
    run(4);
    q0.push_back(mk(1'b0, 10'h3FF, 16'h0, 1'b0));
    run(4);
    checkOutput("read_0x3ff", 32'(rdata), 32'hBEEF);

    // Continuous tie from reset alternates 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 10'(i), 16'h0, 1'b0));
      q1.push_back(mk(1'b0, 10'(i + 8), 16'h0, 1'b0));
    end
    run(26);

    // Locked burst of three CPU reads ahead of a waiting loader.
    do_reset();
    for (int i = 0; i < 3; i++) q0.push_back(mk(1'b0, 10'(16 + i), 16'h0, 1'b1));
    q1.push_back(mk(1'b0, 10'h020, 16'h0, 1'b0));
    run(14);

    // CPU keeps the lock but goes quiet; the watchdog frees the port.
    do_reset();
    idle_lock[0] = 1'b1;
    q0.push_back(mk(1'b0, 10'h030, 16'h0, 1'b1));
    q1.push_back(mk(1'b0, 10'h031, 16'h0, 1'b0));
    run(25);
    checkOutput("wd_lock_err", 32'(lock_err), 32'h1);
    idle_lock[0] = 1'b0;
    q0.push_back(mk(1'b0, 10'h032, 16'h0, 1'b0));
    run(8);
    checkOutput("wd_sticky", 32'(lock_err), 32'h1);

    // Reset lands on the ISSUE cycle of a loader write.
    do_reset();
    q1.push_back(mk(1'b1, 10'h2AA, 16'h5555, 1'b0));
    run(1);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    checkOutput("rst_mid_rw", 32'(mem_read_write), 32'h0);
    q0.push_back(mk(1'b0, 10'h2AA, 16'h0, 1'b0));
    q1.push_back(mk(1'b0, 10'h2AB, 16'h0, 1'b0));
    run(8);

    // Random traffic with occasional locks and lock stalls.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_txn());
      if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_txn());
      if ($urandom_range(0, 15) == 0) idle_lock[$urandom_range(0, 1)] ^= 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 1K x 16 synchronous-read memory port between two requesters: port 0 (CPU fetch/operand/store traffic) and port 1 (program loader / debug access). It runs a three-state access sequencer with round-robin arbitration. A per-port bus lock lets the CPU keep the memory for its fetch, indirect and operand accesses without interleaving. A lock watchdog releases a stuck lock.

## Interface
- AW, 10, memory address width
- DW, 16, memory data width
- LOCK_TIMEOUT, 15, idle cycles a locked owner may hold the port without requesting before the lock is forced off
---
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  2  per-port access request, bit i = port i
- we  in  2  per-port write enable (1 = write, 0 = read)
- lock  in  2  per-port lock: keep ownership after the current access
- addr  in  2*AW  port i address at [i*AW +: AW]
- wdata  in  2*DW  port i write data at [i*DW +: DW]
- gnt  out  2  one-cycle grant pulse, one-hot or zero
- done  out  2  one-cycle completion pulse, same port as the matching gnt
- rdata  out  DW  read data, valid while done is high
- lock_err  out  1  sticky; set by watchdog release, cleared only by reset
- mem_read_write  out  1  1 = write, 0 = read (CPU encoding)
- mem_address  out  AW  memory address
- mem_data_out  out  DW  memory write data
- mem_data_in  in  DW  memory read data, valid the cycle after address is presented

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: drive memory.
  - WAIT: memory latency.
  - Completion pulse is issued on the WAIT→IDLE edge.
- IDLE arbitration, in priority order:
  - Lock holder: if `owner_locked`, only `owner` may be granted. If `req[owner]`=0, stay IDLE and count.
  - Round-robin: otherwise, if both ports request, grant the port ≠ `last`. If one port requests, grant it.
- On grant (IDLE→ISSUE):
  - Register `addr`, `we`, `wdata` of the winner onto the mem_* outputs.
  - Pulse `gnt[w]`.
  - Set `owner`=w and `last`=w.
  - Set `owner_locked`=`lock[w]`.
- ISSUE→WAIT: deassert mem_read_write. A write commits at this edge.
- WAIT→IDLE:
  - Pulse `done[owner]`.
  - `rdata` ← mem_data_in. Done and rdata are also produced for writes; rdata is don't-care then.
  - Re-sample `owner_locked` ← `lock[owner]`.
- Requester rules:
  - Hold `req`/`we`/`addr`/`wdata` stable until `gnt`.
  - Drop `req` or change it in the cycle after `gnt`. A req still high in IDLE is a new access.
- Lock watchdog:
  - The counter increments each IDLE cycle while `owner_locked` and `!req[owner]`, and clears otherwise.
  - When count = LOCK_TIMEOUT: clear `owner_locked`, set `lock_err`, clear the counter. Arbitration is normal from the next cycle.
- Simultaneous events:
  - The lock holder requesting while the other port requests: the lock holder wins.
  - The holder deasserting lock at WAIT→IDLE: normal round-robin on the next IDLE cycle.
- Reset values:
  - State IDLE; `gnt`, `done`, `rdata`, `lock_err` = 0.
  - mem_read_write=0, mem_address=0, mem_data_out=0.
  - `last`=1, so port 0 wins the first tie. `owner`=0, `owner_locked`=0, watchdog count=0.
- Reset mid-access: the access is abandoned with no done pulse, and mem_read_write is forced to 0 at that edge.

## Timing
- Req high before edge E in IDLE:
  - Edge E: gnt high, mem_* driven.
  - Edge E+1: mem_read_write low.
  - Edge E+2: done high, rdata valid.
- Access latency is 3 cycles. Back-to-back throughput is one access per 3 cycles.
- gnt and done never overlap, and at most one bit of each is set.
- All outputs are registered. There is no combinational path from req to any output.

## Structure
- Shared package `mem_pkg`:
  - AW and DW constants.
  - `arb_state_t` enum {IDLE, ISSUE, WAIT}.
  - Port indices `PORT_CPU`=0, `PORT_LDR`=1.
  - `MEM_READ`=0, `MEM_WRITE`=1.
- One sub-module, `rr_pick2`: combinational 2-way round-robin pick with inputs req[1:0], last, force_en, force_idx and outputs valid, idx.
- The sequencer, watchdog and registers stay in `mem_port_arbiter`.

## Test plan
- Single read: port 0 read at addr 0x005, memory holds 0x1234 → gnt[0] at E, done[0] at E+2, rdata=0x1234, mem_read_write low throughout.
- Single write: port 1 writes 0xBEEF at 0x3FF → mem_read_write=1 for exactly one cycle with mem_address=0x3FF and mem_data_out=0xBEEF. A following port-0 read of 0x3FF returns 0xBEEF.
- Tie/round-robin: both ports request continuously from reset → grant order 0,1,0,1, with gnt pulses every 3 cycles.
- Lock: port 0 holds lock for 3 reads (0x010, 0x011, 0x012) while port 1 requests → all three go to port 0 before port 1's first gnt.
- Watchdog: port 0 locked with req low for 15 IDLE cycles while port 1 requests → lock_err=1 and gnt[1] one cycle later. lock_err stays set until reset.
- Reset mid-access: assert reset in ISSUE of a write → no done pulse, mem_read_write=0 after that edge, all outputs at reset values, and the next request is arbitrated with port 0 winning a tie.
